// File: rtl/led_fade_pkg.sv
// Shared defaults for the LED fade/PWM stage and the level-to-duty gamma curve.
// The curve is only used when LED_FADE_GAMMA_EN is defined.
package led_fade_pkg;

  localparam int PWM_BITS_DEF = 4;
  localparam int FADE_DIV_DEF = 8;
  localparam int LED_COUNT    = 8;

  function automatic int unsigned pwm_max(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  // Quadratic perceptual curve: duty = level^2 / 2^bits.
  function automatic logic [15:0] gamma_duty(input logic [15:0] level, input int unsigned bits);
    logic [31:0] sq;
    sq = 32'(level) * 32'(level);
    return 16'(sq >> bits);
  endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED: saturating brightness level plus registered PWM compare.
// Build option LED_FADE_GAMMA_EN selects the quadratic duty curve instead of linear.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target,
  input  logic                fade_tick,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led_out
);

  localparam logic [PWM_BITS-1:0] MAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PWM_BITS-1:0] duty;
  logic                led_q, led_d;

  function automatic logic [PWM_BITS-1:0] sat_step(input logic [PWM_BITS-1:0] lvl,
                                                   input logic up);
    if (up) return (lvl == MAX) ? lvl : lvl + 1'b1;
    return (lvl == '0) ? lvl : lvl - 1'b1;
  endfunction

`ifdef LED_FADE_GAMMA_EN
  always_comb duty = PWM_BITS'(gamma_duty(16'(level_q), PWM_BITS));
`else
  always_comb duty = level_q;
`endif

  // End levels override the compare so full-on never flickers and full-off never glows.
  always_comb begin
    level_d = level_q;
    led_d   = 1'b0;
    if (enable && fade_tick) level_d = sat_step(level_q, target);
    if (!enable)               led_d = 1'b0;
    else if (level_q == MAX)   led_d = 1'b1;
    else if (level_q == '0)    led_d = 1'b0;
    else                       led_d = (duty > pwm_cnt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: rtl/led_fade_pwm.sv
// Fade + PWM brightness stage behind the LEDSANG_TATDAN pattern generator: shared PWM
// and fade-divider counters feeding eight led_fade_channel slices. Option: LED_FADE_GAMMA_EN.
module led_fade_pwm
  import led_fade_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int FADE_DIV = FADE_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pattern_in,
  input  logic       enable,
  output logic [7:0] led_out,
  output logic       pwm_wrap
);

  localparam logic [PWM_BITS-1:0] MAX      = PWM_BITS'(pwm_max(PWM_BITS));
  localparam int                  DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DIV_W-1:0]    fade_div_cnt_q, fade_div_cnt_d;
  logic [7:0]          pattern_q, pattern_d;
  logic                fade_tick;

  assign pwm_wrap = (pwm_cnt_q == MAX);

  // Everything except the pattern register freezes while disabled.
  always_comb begin
    pwm_cnt_d      = pwm_cnt_q;
    fade_div_cnt_d = fade_div_cnt_q;
    pattern_d      = pattern_in;
    fade_tick      = 1'b0;
    if (enable) begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      if (pwm_wrap) begin
        if (fade_div_cnt_q == DIV_LAST) begin
          fade_div_cnt_d = '0;
          fade_tick      = 1'b1;
        end else begin
          fade_div_cnt_d = fade_div_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q      <= '0;
      fade_div_cnt_q <= '0;
      pattern_q      <= '0;
    end else begin
      pwm_cnt_q      <= pwm_cnt_d;
      fade_div_cnt_q <= fade_div_cnt_d;
      pattern_q      <= pattern_d;
    end
  end

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    led_fade_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .target    (pattern_q[i]),
      .fade_tick (fade_tick),
      .enable    (enable),
      .pwm_cnt   (pwm_cnt_q),
      .led_out   (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm: a cycle-count reference model queues the expected
// outputs each clock and a negedge monitor pops and compares them.
module tb_led_fade_pwm;

  localparam int PB    = 4;
  localparam int FD    = 2;
  localparam int MAXV  = (1 << PB) - 1;
  localparam int PER   = 1 << PB;
  localparam int TICKP = PER * FD;
`ifdef LED_FADE_GAMMA_EN
  localparam int DUTY_LVL = 8;
  localparam int DUTY_EXP = 4;
`else
  localparam int DUTY_LVL = 5;
  localparam int DUTY_EXP = 5;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] pattern_in = 8'h00;
  logic [7:0] led_out;
  logic       pwm_wrap;

  always #5 clk = ~clk;

  led_fade_pwm #(.PWM_BITS(PB), .FADE_DIV(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .pattern_in (pattern_in),
    .enable     (enable),
    .led_out    (led_out),
    .pwm_wrap   (pwm_wrap)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] led;
    logic       wrap;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: total enabled cycles since reset give the PWM phase and tick times.
  int         e_cnt = 0;
  int         lvl[8] = '{default: 0};
  logic [7:0] pq = 8'h00;

  function automatic int duty_of(input int l);
`ifdef LED_FADE_GAMMA_EN
    return (l * l) / PER;
`else
    return l;
`endif
  endfunction

  initial forever begin
    exp_t x;
    @(posedge clk or negedge reset);
    if (!reset) begin
      e_cnt = 0;
      for (int i = 0; i < 8; i++) lvl[i] = 0;
      pq = 8'h00;
      sb_q.delete();
    end else begin
      for (int i = 0; i < 8; i++)
        x.led[i] = enable && (lvl[i] == MAXV ||
                              (lvl[i] != 0 && duty_of(lvl[i]) > (e_cnt % PER)));
      if (enable) begin
        if (e_cnt % TICKP == TICKP - 1)
          for (int i = 0; i < 8; i++)
            lvl[i] = pq[i] ? ((lvl[i] < MAXV) ? lvl[i] + 1 : MAXV)
                           : ((lvl[i] > 0) ? lvl[i] - 1 : 0);
        e_cnt++;
      end
      pq = pattern_in;
      x.wrap = ((e_cnt % PER) == PER - 1);
      sb_q.push_back(x);
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    exp_t x;
    @(negedge clk);
    if (!reset) begin
      check("reset_led_out", led_out, 8'h00);
      check("reset_pwm_wrap", {7'd0, pwm_wrap}, 8'h00);
    end else if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("sb_led_out", led_out, x.led);
      check("sb_pwm_wrap", {7'd0, pwm_wrap}, {7'd0, x.wrap});
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_lvl(input int ch, input int target, input int budget);
    int k = 0;
    while (lvl[ch] != target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (lvl[ch] != target) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_level: level %0d not reached within %0d cycles at %0t",
               target, budget, $time);
    end
  endtask

  task automatic hold_check(input string name, input logic [7:0] exp, input int n);
    int good = 0;
    repeat (n) begin
      @(negedge clk);
      if (led_out === exp) good++;
    end
    check_int(name, good, n);
  endtask

  initial begin
    int cnt;
    reset = 1'b0; enable = 1'b1; pattern_in = 8'h00;
    cycles(3);
    reset = 1'b1;

    // Idle: dark outputs, wrap every 16 cycles.
    hold_check("idle_dark", 8'h00, 440);
    cnt = 0;
    repeat (160) begin
      @(negedge clk);
      if (pwm_wrap) cnt++;
    end
    check_int("idle_wrap_count", cnt, 10);

    // Ramp LED0 up, measure duty on one level, freeze mid-ramp.
    pattern_in = 8'h01;
    wait_lvl(0, DUTY_LVL, 600);
    cnt = 0;
    repeat (16) begin
      @(negedge clk);
      if (led_out[0]) cnt++;
    end
    check_int("duty_16", cnt, DUTY_EXP);
    enable = 1'b0;
    @(negedge clk);
    check("freeze_dark", led_out, 8'h00);
    cycles(99);
    enable = 1'b1;
    cycles(500);
    hold_check("ramp_up_full", 8'h01, 32);

    // All LEDs full, full ramp down, then reversal at level 7.
    pattern_in = 8'hFF;
    cycles(500);
    hold_check("all_full", 8'hFF, 32);
    pattern_in = 8'h00;
    cycles(500);
    hold_check("all_dark", 8'h00, 20);
    pattern_in = 8'hFF;
    cycles(500);
    pattern_in = 8'h00;
    wait_lvl(0, 7, 600);
    pattern_in = 8'hFF;
    wait_lvl(0, 8, 40);

    // Asynchronous reset between edges at level 9.
    wait_lvl(0, 9, 200);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_led", led_out, 8'h00);
    check("async_rst_wrap", {7'd0, pwm_wrap}, 8'h00);
    cycles(2);
    reset = 1'b1;
    wait_lvl(0, 3, 200);

    // Random patterns and enable gaps.
    repeat (1500) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) pattern_in = 8'($urandom);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
    end
    enable = 1'b1;
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    n_err++;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
